// File: rtl/serial_add_pkg.sv
// serial_add_pkg: FSM states and counter sizing shared by the bit-serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder, time-shared across all bit positions
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder with valid/ready on both sides
// SERIAL_ADD_SUB_EN adds a sub input that turns the operation into a-b
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res, b_ld;
  logic [CW-1:0] cnt;
  logic carry, c_ld, s, c;
`ifdef SERIAL_ADD_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif
  fa_cell u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .s(s), .co(c));
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (in_valid ? RUN : IDLE) :
               (state == RUN)  ? ((cnt == CW'(WIDTH-1)) ? DONE : RUN) :
                                 (out_ready ? IDLE : DONE);
  end
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = res;
  assign cout      = carry;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_sh  <= a;
        b_sh  <= b_ld;
        carry <= c_ld;
        cnt   <= '0;
        res   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        res   <= WIDTH'({s, res} >> 1);
        carry <= c;
        cnt   <= cnt + CW'(1);
      end
    end
  end
endmodule
